pint_rx_formatter: RTL
======================

# pint_rx_formatter

Converts received PINT messages into ASCII response lines for the host UART. Sits between the PINT interface's receive outputs and the UART transmitter. Each message is captured, buffered one deep, and emitted as header char, hex digits, end-of-line, paced by the UART `tx_empty` handshake. Replaces the single raw-byte PINT response path in the controller RX state machine.

## Interface
Parameters:
- `HEADER_CHAR`, 8'h61 ('a'): first character of every response line.
- `EOL_CHAR`, 8'h0a: last character of every response line.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `rx_latch`  in  1  one-cycle pulse: `rx_data`/`rx_num_bytes` valid.
- `rx_data`  in  40  message payload; byte i at [8i+7:8i].
- `rx_num_bytes`  in  3  valid byte count, 0..5.
- `tx_empty`  in  1  UART ready for a character.
- `tx_latch`  out  1  one-cycle pulse: `tx_data` to UART.
- `tx_data`  out  8  character to transmit.
- `busy`  out  1  active message or pending message present.
- `drop_count`  out  8  dropped-message count (see Configuration).

## Operation
- Active register (data, count) plus one pending slot (data, count, valid).
- Count clamp: `rx_num_bytes` 6 or 7 is stored as 5.
- States:
  - IDLE: waits for pending valid or `rx_latch`.
  - HDR: emits `HEADER_CHAR`.
  - NIB_HI: emits high nibble of byte `idx`.
  - NIB_LO: emits low nibble of byte `idx`.
  - EOL: emits `EOL_CHAR`.
- Emission order: byte 0 first; high nibble before low nibble.
- Hex encoding: 0-9 become 8'h30-8'h39; A-F become lowercase 8'h61-8'h66.
- Transitions:
  - HDR goes to NIB_HI when count>0, else to EOL.
  - NIB_LO goes to NIB_HI with `idx+1` when `idx+1 < count`, else to EOL.
  - EOL returns to IDLE, or directly to HDR if pending valid.
- Character emission:
  - `tx_latch` = `tx_empty` & emitting state & !`gap`.
  - `gap` is a register set for exactly one cycle after each `tx_latch`, so a `tx_empty` still high from the previous character is not reused.
  - State advances only on the `tx_latch` cycle.
- Message acceptance:
  - `rx_latch` in IDLE with no pending message: loads the active register and goes to HDR.
  - Otherwise `rx_latch` loads pending if pending is empty.
  - If pending is full, the message is dropped and `drop_count` increments.
- Simultaneous `rx_latch` and EOL `tx_latch`: the new message goes to pending. The old pending message, if any, moves to active in the same cycle, so no drop occurs.
- `idx` is 3 bits. Comparisons use the clamped count, never the raw input.
- `tx_data` = 0 when not in an emitting state.

## Timing
- Reset values:
  - `tx_latch`=0, `tx_data`=0, `busy`=0, `drop_count`=0.
  - State IDLE, pending invalid, `gap`=0, `idx`=0.
- Reset mid-line aborts immediately. No EOL is sent and both buffers are cleared.
- Latency: `rx_latch` at cycle N puts the state in HDR at N+1. `tx_latch` for the header can be high at N+1 if `tx_empty` is high.
- Character rate: at most one character per 2 cycles. A line of n bytes is 2+2n characters.
- `busy` is registered. It is high from N+1 until the cycle after the final EOL latch with pending empty.

## Configuration
- `PINT_RX_DROP_CNT_EN` defined:
  - `drop_count` is an 8-bit saturating counter that holds at 255.
  - Increments once per dropped message; cleared only by reset.
- Not defined: `drop_count` is tied to 0 and the counter logic is absent. Drop behaviour is otherwise unchanged.

## Structure
- Shared package: default header/EOL characters, state encoding, max byte count (5), ASCII offsets (8'h30, 8'h57).
- One sub-module: `hex_ascii_enc`, a combinational 4-bit nibble to 8-bit ASCII encoder, instantiated once on the selected nibble.

## Test plan
- `rx_data`=40'h00000000A5, count 1, `tx_empty` held high → latches 'a','a','5',8'h0a (8'h61,8'h61,8'h35,8'h0a), one every 2 cycles; `busy` then drops.
- Count 0 → exactly 8'h61, 8'h0a; count 7 with 40'h0403020100 → "a0001020304\n" (5 bytes, clamp).
- `tx_empty` low for 20 cycles after the header → no `tx_latch` while low; the next character is latched on the first cycle it goes high.
- Three `rx_latch` pulses back-to-back during line 1 → lines 1 and 2 emitted intact; `drop_count`=1 with the macro, 0 without.
- `rx_latch` on the same cycle as the EOL latch, with pending empty → second line's header follows with no drop.
- Reset asserted mid-NIB_LO → next cycle `tx_latch`=0, `busy`=0, a new message starts cleanly with a header.

Source files
------------

// File: rtl/pint_rx_formatter_pkg.sv
// pint_rx_formatter_pkg
// Shared definitions for the PINT receive formatter: default line framing
// characters, FSM state encoding, maximum payload byte count, ASCII offsets
// used by the nibble encoder, and the byte-count clamp helper.
package pint_rx_formatter_pkg;

   localparam logic [7:0] DEF_HEADER_CHAR = 8'h61;
   localparam logic [7:0] DEF_EOL_CHAR    = 8'h0a;
   localparam logic [2:0] MAX_BYTES       = 3'd5;
   localparam logic [7:0] ASCII_DIGIT_OFS = 8'h30;
   // 8'h57 + 10 = 8'h61, so nibbles A-F land on lowercase 'a'-'f'
   localparam logic [7:0] ASCII_ALPHA_OFS = 8'h57;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_HDR    = 3'd1,
      ST_NIB_HI = 3'd2,
      ST_NIB_LO = 3'd3,
      ST_EOL    = 3'd4
   } state_e;

   // Byte counts 6 and 7 are stored as 5.
   function automatic logic [2:0] clamp_count(input logic [2:0] n);
      return (n > MAX_BYTES) ? MAX_BYTES : n;
   endfunction

endpackage

// File: rtl/pint_rx_formatter_hex_ascii_enc.sv
// hex_ascii_enc
// Combinational 4-bit nibble to lowercase ASCII hex character encoder.
// Ports:
//   nib_i    4-bit value to encode
//   ascii_o  8'h30-8'h39 for 0-9, 8'h61-8'h66 for A-F
module hex_ascii_enc
   import pint_rx_formatter_pkg::*;
(
   input  logic [3:0] nib_i,
   output logic [7:0] ascii_o
);

   always_comb begin
      if (nib_i < 4'd10) ascii_o = ASCII_DIGIT_OFS + {4'b0000, nib_i};
      else               ascii_o = ASCII_ALPHA_OFS + {4'b0000, nib_i};
   end

endmodule

// File: rtl/pint_rx_formatter.sv
// pint_rx_formatter
// Turns received PINT messages into ASCII response lines for the host UART:
// header char, two lowercase hex digits per payload byte (byte 0 first, high
// nibble first), end-of-line char. One active message plus one pending slot;
// a message arriving while both are occupied is dropped.
// Characters are paced by tx_empty; a one-cycle gap after every tx_latch keeps
// a stale tx_empty from the previous character from being reused.
//
// Optional feature: define PINT_RX_DROP_CNT_EN to get an 8-bit saturating
// dropped-message counter on drop_count; otherwise drop_count is tied to 0.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   rx_latch            one-cycle pulse, rx_data/rx_num_bytes valid
//   rx_data[39:0]       payload, byte i at [8i+7:8i]
//   rx_num_bytes[2:0]   valid byte count (6,7 treated as 5)
//   tx_empty            UART ready for a character
//   tx_latch            one-cycle pulse, tx_data to UART
//   tx_data[7:0]        character, 0 when not emitting
//   busy                registered, active or pending message present
//   drop_count[7:0]     dropped-message count
//
// state     | meaning
// ----------+--------------------------------------------------
// ST_IDLE   | nothing to send, waiting for pending or rx_latch
// ST_HDR    | emitting HEADER_CHAR
// ST_NIB_HI | emitting high nibble of active byte idx
// ST_NIB_LO | emitting low nibble of active byte idx
// ST_EOL    | emitting EOL_CHAR
module pint_rx_formatter
   import pint_rx_formatter_pkg::*;
#(
   parameter logic [7:0] HEADER_CHAR = DEF_HEADER_CHAR,
   parameter logic [7:0] EOL_CHAR    = DEF_EOL_CHAR
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        rx_latch,
   input  logic [39:0] rx_data,
   input  logic [2:0]  rx_num_bytes,
   input  logic        tx_empty,
   output logic        tx_latch,
   output logic [7:0]  tx_data,
   output logic        busy,
   output logic [7:0]  drop_count
);

   state_e      state_q, state_d;
   logic [2:0]  idx_q, idx_d;
   logic        gap_q, gap_d;
   logic [39:0] act_data_q, act_data_d;
   logic [2:0]  act_cnt_q, act_cnt_d;
   logic [39:0] pend_data_q, pend_data_d;
   logic [2:0]  pend_cnt_q, pend_cnt_d;
   logic        pend_vld_q, pend_vld_d;
   logic        busy_q, busy_d;

   logic        emitting;
   logic        eol_done;
   logic        start_from_pend;
   logic        load_active;
   logic        pend_free;
   logic [2:0]  rx_cnt;
   logic [2:0]  idx_nxt;
   logic [7:0]  byte_sel;
   logic [3:0]  nib_sel;
   logic [7:0]  nib_ascii;

   assign rx_cnt          = clamp_count(rx_num_bytes);
   assign idx_nxt         = idx_q + 3'd1;
   assign eol_done        = (state_q == ST_EOL) && tx_latch;
   // Pending hands over to active either when the current line finishes or
   // when it was filled on the very EOL cycle and the FSM fell back to idle.
   assign start_from_pend = pend_vld_q && ((state_q == ST_IDLE) || eol_done);
   assign load_active     = (state_q == ST_IDLE) && !pend_vld_q;
   assign pend_free       = !pend_vld_q || start_from_pend;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         gap_q       <= 1'b0;
         act_data_q  <= '0;
         act_cnt_q   <= '0;
         pend_data_q <= '0;
         pend_cnt_q  <= '0;
         pend_vld_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         gap_q       <= gap_d;
         act_data_q  <= act_data_d;
         act_cnt_q   <= act_cnt_d;
         pend_data_q <= pend_data_d;
         pend_cnt_q  <= pend_cnt_d;
         pend_vld_q  <= pend_vld_d;
         busy_q      <= busy_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      gap_d       = tx_latch;
      act_data_d  = act_data_q;
      act_cnt_d   = act_cnt_q;
      pend_data_d = pend_data_q;
      pend_cnt_d  = pend_cnt_q;
      pend_vld_d  = pend_vld_q;

      case (state_q)
         ST_IDLE: begin
            if (pend_vld_q || rx_latch) state_d = ST_HDR;
         end
         ST_HDR: begin
            idx_d = '0;
            if (tx_latch) state_d = (act_cnt_q != 3'd0) ? ST_NIB_HI : ST_EOL;
         end
         ST_NIB_HI: begin
            if (tx_latch) state_d = ST_NIB_LO;
         end
         ST_NIB_LO: begin
            if (tx_latch) begin
               if (idx_nxt < act_cnt_q) begin
                  state_d = ST_NIB_HI;
                  idx_d   = idx_nxt;
               end else begin
                  state_d = ST_EOL;
               end
            end
         end
         ST_EOL: begin
            if (tx_latch) state_d = pend_vld_q ? ST_HDR : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (start_from_pend) begin
         act_data_d = pend_data_q;
         act_cnt_d  = pend_cnt_q;
         pend_vld_d = 1'b0;
      end

      if (rx_latch) begin
         if (load_active) begin
            act_data_d = rx_data;
            act_cnt_d  = rx_cnt;
         end else if (pend_free) begin
            pend_data_d = rx_data;
            pend_cnt_d  = rx_cnt;
            pend_vld_d  = 1'b1;
         end
      end

      busy_d = (state_d != ST_IDLE) || pend_vld_d;
   end

   // Output logic
   always_comb begin
      case (idx_q)
         3'd0:    byte_sel = act_data_q[7:0];
         3'd1:    byte_sel = act_data_q[15:8];
         3'd2:    byte_sel = act_data_q[23:16];
         3'd3:    byte_sel = act_data_q[31:24];
         3'd4:    byte_sel = act_data_q[39:32];
         default: byte_sel = 8'h00;
      endcase
      nib_sel  = (state_q == ST_NIB_HI) ? byte_sel[7:4] : byte_sel[3:0];
      emitting = (state_q == ST_HDR) || (state_q == ST_NIB_HI) ||
                 (state_q == ST_NIB_LO) || (state_q == ST_EOL);
      tx_latch = tx_empty && emitting && !gap_q;
      case (state_q)
         ST_HDR:              tx_data = HEADER_CHAR;
         ST_NIB_HI, ST_NIB_LO: tx_data = nib_ascii;
         ST_EOL:              tx_data = EOL_CHAR;
         default:             tx_data = 8'h00;
      endcase
   end

   hex_ascii_enc u_hex_ascii_enc (
      .nib_i   (nib_sel),
      .ascii_o (nib_ascii)
   );

   assign busy = busy_q;

`ifdef PINT_RX_DROP_CNT_EN
   logic       drop_inc;
   logic [7:0] drop_q, drop_d;

   assign drop_inc = rx_latch && !load_active && !pend_free;

   always_comb begin
      drop_d = drop_q;
      if (drop_inc && (drop_q != 8'hff)) drop_d = drop_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) drop_q <= '0;
      else       drop_q <= drop_d;
   end

   assign drop_count = drop_q;
`else
   assign drop_count = 8'h00;
`endif

endmodule
